mux_cfg_shadow_chain: RTL



---
 rtl/mux_cfg_shadow_chain.sv | 114 +++++++++++
 1 files changed

// File: rtl/mux_cfg_shadow_chain.sv
// Configuration chain with an atomic shadow register feeding the mux trees' sram/sram_inv.
// Bits shift in serially under valid/ready. A commit then copies the full frame into the shadow,
// so the routing muxes never see a partially shifted select value.
module mux_cfg_shadow_chain #(
    parameter int unsigned NUM_MUX = 4,
    parameter int unsigned SRAM_W  = 6,
    localparam int unsigned TOTAL  = NUM_MUX * SRAM_W
) (
    input  logic             prog_clk,
    input  logic             prog_reset_n,
    input  logic             ccff_head,
    input  logic             ccff_valid,
    output logic             ccff_ready,
    output logic             ccff_tail,
    input  logic             cfg_commit,
    input  logic             cfg_abort,
    output logic             commit_ack,
    output logic             frame_full,
    output logic             err_commit,
    output logic [TOTAL-1:0] mem_out,
    output logic [TOTAL-1:0] mem_outb
);

    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] TotalCnt = CNT_W'(TOTAL);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFull
    } state_e;

    state_e             state_q, state_d;
    logic [TOTAL-1:0]   chain_q, chain_d;
    logic [TOTAL-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               handshake;
    logic [CNT_W-1:0]   cnt_inc;

    assign ccff_ready = (state_q != StFull);
    assign handshake  = ccff_valid & ccff_ready;
    assign cnt_inc    = bit_cnt_q + CNT_W'(1);

    // Next-state: abort overrides everything, including a commit in the same cycle.
    always_comb begin
        state_d   = state_q;
        chain_d   = chain_q;
        shadow_d  = shadow_q;
        bit_cnt_d = bit_cnt_q;
        ack_d     = 1'b0;
        err_d     = err_q;

        if (cfg_commit && (state_q != StFull)) begin
            err_d = 1'b1;
        end

        if (cfg_abort) begin
            // Chain contents stay but can no longer be committed.
            bit_cnt_d = '0;
            state_d   = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StShift: begin
                    if (handshake) begin
                        // Shift form also works when TOTAL is 1.
                        chain_d   = (chain_q << 1) | TOTAL'(ccff_head);
                        bit_cnt_d = cnt_inc;
                        state_d   = (cnt_inc == TotalCnt) ? StFull : StShift;
                    end
                end
                StFull: begin
                    if (cfg_commit) begin
                        shadow_d  = chain_q;
                        ack_d     = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers; reset clears the shadow so every mux falls back to its const1 path.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q   <= StIdle;
            chain_q   <= '0;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            chain_q   <= chain_d;
            shadow_q  <= shadow_d;
            bit_cnt_q <= bit_cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign ccff_tail  = chain_q[TOTAL-1];
    assign frame_full = (state_q == StFull);
    assign commit_ack = ack_q;
    assign err_commit = err_q;
    assign mem_out    = shadow_q;
    assign mem_outb   = ~shadow_q;

endmodule
